// File: rtl/if_id_branch_ctrl_pkg.sv
// Shared widths, opcodes and instruction field layout for the IF/ID branch controller.
package if_id_branch_ctrl_pkg;

  localparam int unsigned WORD_LEN     = 32;
  localparam int unsigned REG_ADDR_LEN = 5;
  localparam int unsigned OPCODE_LEN   = 6;
  localparam int unsigned IMM_LEN      = 16;

  // Field bit positions within an instruction word.
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;

  typedef enum logic [OPCODE_LEN-1:0] {
    OpRtype = 6'd0,
    OpLd    = 6'd36,
    OpSt    = 6'd37,
    OpBez   = 6'd40,
    OpBne   = 6'd41,
    OpJmp   = 6'd42
  } opcode_e;

  typedef struct packed {
    logic [OPCODE_LEN-1:0]   opcode;
    logic [REG_ADDR_LEN-1:0] rs;
    logic [REG_ADDR_LEN-1:0] rt;
    logic [IMM_LEN-1:0]      imm;
  } instr_t;

  function automatic logic [WORD_LEN-1:0] sext_imm(input logic [IMM_LEN-1:0] imm);
    return {{(WORD_LEN - IMM_LEN){imm[IMM_LEN-1]}}, imm};
  endfunction

endpackage

// File: rtl/if_id_branch_ctrl_if.sv
// Fetch-stage interface: fetched PC/instruction forward, redirect and freeze back.
interface if_id_branch_ctrl_if;
  import if_id_branch_ctrl_pkg::*;

  logic [WORD_LEN-1:0] if_pc;
  logic [WORD_LEN-1:0] if_instruction;
  logic                brTaken;
  logic [WORD_LEN-1:0] brOffset;
  logic                freeze;

  // Fetch stage side.
  modport master (
    output if_pc,
    output if_instruction,
    input  brTaken,
    input  brOffset,
    input  freeze
  );

  // IF/ID register side.
  modport slave (
    input  if_pc,
    input  if_instruction,
    output brTaken,
    output brOffset,
    output freeze
  );

endinterface

// File: rtl/if_id_branch_ctrl_hazard.sv
// Source-use decode of the ID instruction and EX/MEM destination compare.
module if_id_branch_ctrl_hazard
  import if_id_branch_ctrl_pkg::*;
(
  input  logic                    valid,
  input  instr_t                  instr,
  input  logic                    exe_wb_en,
  input  logic                    exe_mem_read,
  input  logic [REG_ADDR_LEN-1:0] exe_dest,
  input  logic                    mem_mem_read,
  input  logic [REG_ADDR_LEN-1:0] mem_dest,
  output logic                    freeze
);

  logic uses_rs;
  logic uses_rt;
  logic is_branch;
  logic exe_match;
  logic mem_match;
  logic load_use;
  logic branch_hazard;

  // Which sources the ID instruction reads; a bubble reads nothing.
  always_comb begin
    uses_rs   = valid && (instr.opcode != OpJmp);
    uses_rt   = valid && ((instr.opcode == OpRtype) || (instr.opcode == OpBne) ||
                          (instr.opcode == OpSt));
    is_branch = valid && ((instr.opcode == OpBez) || (instr.opcode == OpBne));
  end

  // Register 0 is hard-wired, so it never creates a dependency.
  always_comb begin
    exe_match = (exe_dest != '0) &&
                ((uses_rs && (exe_dest == instr.rs)) || (uses_rt && (exe_dest == instr.rt)));
    mem_match = (mem_dest != '0) &&
                ((uses_rs && (mem_dest == instr.rs)) || (uses_rt && (mem_dest == instr.rt)));
    load_use      = exe_mem_read && exe_match;
    // Branches compare in ID, so any in-flight producer not yet forwardable must stall.
    branch_hazard = is_branch && ((exe_wb_en && exe_match) || (mem_mem_read && mem_match));
    freeze        = load_use || branch_hazard;
  end

endmodule

// File: rtl/if_id_branch_ctrl.sv
// IF/ID pipeline register with ID-stage branch resolution, stall insertion and counters.
module if_id_branch_ctrl
  import if_id_branch_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  if_id_branch_ctrl_if.slave      fetch,
  output logic [REG_ADDR_LEN-1:0] rf_src1,
  output logic [REG_ADDR_LEN-1:0] rf_src2,
  input  logic [WORD_LEN-1:0]     rf_val1,
  input  logic [WORD_LEN-1:0]     rf_val2,
  input  logic                    exe_wb_en,
  input  logic                    exe_mem_read,
  input  logic [REG_ADDR_LEN-1:0] exe_dest,
  input  logic                    mem_wb_en,
  input  logic                    mem_mem_read,
  input  logic [REG_ADDR_LEN-1:0] mem_dest,
  output logic                    id_valid,
  output logic [WORD_LEN-1:0]     id_pc,
  output logic [WORD_LEN-1:0]     id_instruction,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  logic                valid_q;
  logic [WORD_LEN-1:0] pc_q;
  instr_t              instr_q;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic [CNT_W-1:0]    flush_cnt_q;

  logic hazard;
  logic freeze;
  logic cond;
  logic br_taken;

  // MEM writes are already forwardable to the ID compare; only MEM loads matter.
  logic unused_mem_wb_en;
  assign unused_mem_wb_en = mem_wb_en;

  if_id_branch_ctrl_hazard u_hazard (
    .valid        (valid_q),
    .instr        (instr_q),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_read (exe_mem_read),
    .exe_dest     (exe_dest),
    .mem_mem_read (mem_mem_read),
    .mem_dest     (mem_dest),
    .freeze       (hazard)
  );

  // Branch condition and control outputs; reset forces all controls low.
  always_comb begin
    unique case (instr_q.opcode)
      OpBez:   cond = (rf_val1 == '0);
      OpBne:   cond = (rf_val1 != rf_val2);
      OpJmp:   cond = 1'b1;
      default: cond = 1'b0;
    endcase
    freeze   = hazard && !rst;
    // A stalled branch is re-evaluated once its operands are ready.
    br_taken = valid_q && cond && !freeze && !rst;
  end

  assign fetch.freeze   = freeze;
  assign fetch.brTaken  = br_taken;
  assign fetch.brOffset = sext_imm(instr_q.imm);

  assign rf_src1        = instr_q.rs;
  assign rf_src2        = instr_q.rt;
  assign id_valid       = valid_q && !freeze && !rst;
  assign id_pc          = pc_q;
  assign id_instruction = instr_q;
  assign stall_cnt      = stall_cnt_q;
  assign flush_cnt      = flush_cnt_q;

  // Pipeline register: hold on freeze, squash the fetched slot on a taken redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (freeze) begin
      valid_q <= valid_q;
    end else if (br_taken) begin
      valid_q <= 1'b0;
      pc_q    <= fetch.if_pc;
      instr_q <= '0;
    end else begin
      valid_q <= 1'b1;
      pc_q    <= fetch.if_pc;
      instr_q <= fetch.if_instruction;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (freeze && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (br_taken && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_id_branch_ctrl.sv
// Randomized and directed bench for if_id_branch_ctrl against a rule-level model.
module tb_if_id_branch_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  rf_src1;
  logic [4:0]  rf_src2;
  logic [31:0] rf_val1;
  logic [31:0] rf_val2;
  logic        exe_wb_en;
  logic        exe_mem_read;
  logic [4:0]  exe_dest;
  logic        mem_wb_en;
  logic        mem_mem_read;
  logic [4:0]  mem_dest;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  if_id_branch_ctrl_if fetch_bus ();

  if_id_branch_ctrl #(.CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch          (fetch_bus),
    .rf_src1        (rf_src1),
    .rf_src2        (rf_src2),
    .rf_val1        (rf_val1),
    .rf_val2        (rf_val2),
    .exe_wb_en      (exe_wb_en),
    .exe_mem_read   (exe_mem_read),
    .exe_dest       (exe_dest),
    .mem_wb_en      (mem_wb_en),
    .mem_mem_read   (mem_mem_read),
    .mem_dest       (mem_dest),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instruction (id_instruction),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model of the ID slot and counters.
  bit          m_known = 0;
  bit          m_valid;
  int unsigned m_pc;
  int unsigned m_instr;
  int unsigned m_stall;
  int unsigned m_flush;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rs, input int rt, input int imm);
    logic [5:0]  o = 6'(op);
    logic [4:0]  s = 5'(rs);
    logic [4:0]  t = 5'(rt);
    logic [15:0] i = 16'(imm);
    return {o, s, t, i};
  endfunction

  // Called just after a negedge with inputs applied; checks, then advances one clock.
  task automatic cycle();
    int unsigned op, rs, rt, imm, dst;
    bit use_rs, use_rt, exe_hit, mem_hit, e_freeze, e_taken, c;
    int off;
    #2;
    op  = m_instr / (1 << 26);
    rs  = (m_instr / (1 << 21)) % 32;
    rt  = (m_instr / (1 << 16)) % 32;
    imm = m_instr % 65536;
    off = (imm >= 32768) ? int'(imm) - 65536 : int'(imm);
    use_rs = m_valid && op != 42;
    use_rt = m_valid && (op == 0 || op == 41 || op == 37);
    dst = exe_dest;
    exe_hit = dst != 0 && ((use_rs && dst == rs) || (use_rt && dst == rt));
    dst = mem_dest;
    mem_hit = dst != 0 && ((use_rs && dst == rs) || (use_rt && dst == rt));
    e_freeze = !rst && ((exe_mem_read && exe_hit) ||
               (m_valid && (op == 40 || op == 41) &&
                ((exe_wb_en && exe_hit) || (mem_mem_read && mem_hit))));
    c = (op == 40 && rf_val1 == 0) || (op == 41 && rf_val1 != rf_val2) || op == 42;
    e_taken = !rst && m_valid && c && !e_freeze;

    check_eq("freeze", 32'(fetch_bus.freeze), 32'(e_freeze));
    check_eq("brTaken", 32'(fetch_bus.brTaken), 32'(e_taken));
    check_eq("id_valid", 32'(id_valid), 32'(!rst && m_valid && !e_freeze));
    if (m_known) begin
      check_eq("brOffset", fetch_bus.brOffset, 32'(off));
      check_eq("id_pc", id_pc, m_pc);
      check_eq("id_instruction", id_instruction, m_instr);
      check_eq("rf_src1", 32'(rf_src1), rs);
      check_eq("rf_src2", 32'(rf_src2), rt);
      check_eq("stall_cnt", 32'(stall_cnt), m_stall);
      check_eq("flush_cnt", 32'(flush_cnt), m_flush);
    end

    @(posedge clk);
    if (rst) begin
      m_known = 1;
      m_valid = 0; m_pc = 0; m_instr = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (e_freeze && m_stall < 65535) m_stall++;
      if (e_taken && m_flush < 65535) m_flush++;
      if (e_freeze) begin
        // held
      end else if (e_taken) begin
        m_valid = 0; m_instr = 0; m_pc = fetch_bus.if_pc;
      end else begin
        m_valid = 1; m_instr = fetch_bus.if_instruction; m_pc = fetch_bus.if_pc;
      end
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    exe_wb_en = 0; exe_mem_read = 0; exe_dest = 0;
    mem_wb_en = 0; mem_mem_read = 0; mem_dest = 0;
  endtask

  task automatic randomize_inputs();
    int ops[7] = '{0, 36, 37, 40, 41, 42, 0};
    int op;
    op = ops[$urandom_range(0, 6)];
    if ($urandom_range(0, 9) == 0) op = $urandom_range(0, 63);
    fetch_bus.if_pc          = $urandom & 32'hFFFC;
    fetch_bus.if_instruction = mk(op, $urandom_range(0, 4), $urandom_range(0, 4), $urandom);
    rf_val1      = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(0, 3));
    rf_val2      = 32'($urandom_range(0, 3));
    exe_wb_en    = $urandom_range(0, 3) == 0;
    exe_mem_read = $urandom_range(0, 3) == 0;
    exe_dest     = 5'($urandom_range(0, 4));
    mem_wb_en    = $urandom_range(0, 1);
    mem_mem_read = $urandom_range(0, 3) == 0;
    mem_dest     = 5'($urandom_range(0, 4));
  endtask

  initial begin
    rst = 1;
    randomize_inputs();
    @(negedge clk);
    // Reset with random inputs.
    for (int i = 0; i < 2; i++) begin
      randomize_inputs();
      cycle();
    end
    rst = 0;
    check_eq("rst_id_instruction", id_instruction, 32'h0);
    check_eq("rst_stall_cnt", 32'(stall_cnt), 32'h0);

    // Straight line RTYPE.
    quiet();
    rf_val1 = 1; rf_val2 = 1;
    for (int i = 1; i <= 3; i++) begin
      fetch_bus.if_pc = 32'(4 * i);
      fetch_bus.if_instruction = mk(0, 1, 2, i);
      cycle();
    end
    check_eq("line_id_pc", id_pc, 32'd12);

    // Taken BNE with negative offset.
    fetch_bus.if_pc = 16;
    fetch_bus.if_instruction = mk(41, 1, 2, -3);
    cycle();
    rf_val1 = 5; rf_val2 = 6;
    fetch_bus.if_pc = 20;
    fetch_bus.if_instruction = mk(0, 7, 7, 0);
    #1;
    check_eq("bne_taken", 32'(fetch_bus.brTaken), 32'd1);
    check_eq("bne_offset", fetch_bus.brOffset, 32'hFFFFFFFD);
    cycle();
    check_eq("bne_squash", 32'(id_valid), 32'd0);
    check_eq("bne_flush_cnt", 32'(flush_cnt), 32'd1);

    // Load-use on rs.
    fetch_bus.if_pc = 8;
    fetch_bus.if_instruction = mk(0, 3, 5, 0);
    cycle();
    exe_mem_read = 1; exe_dest = 3;
    #1;
    check_eq("lu_freeze", 32'(fetch_bus.freeze), 32'd1);
    cycle();
    quiet();
    check_eq("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    cycle();
    // Destination 0 never stalls.
    fetch_bus.if_instruction = mk(0, 0, 0, 0);
    cycle();
    exe_mem_read = 1; exe_dest = 0;
    #1;
    check_eq("lu_r0_freeze", 32'(fetch_bus.freeze), 32'd0);
    cycle();
    quiet();

    // Branch hazard on BEZ: EX producer, then MEM load, then resolve.
    fetch_bus.if_instruction = mk(40, 4, 0, 2);
    cycle();
    rf_val1 = 0;
    fetch_bus.if_instruction = mk(0, 9, 9, 0);
    exe_wb_en = 1; exe_dest = 4;
    #1;
    check_eq("bh_exe_taken", 32'(fetch_bus.brTaken), 32'd0);
    cycle();
    quiet();
    mem_mem_read = 1; mem_dest = 4;
    #1;
    check_eq("bh_mem_freeze", 32'(fetch_bus.freeze), 32'd1);
    cycle();
    quiet();
    #1;
    check_eq("bh_resolved_taken", 32'(fetch_bus.brTaken), 32'd1);
    cycle();

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 0;

    // Saturation: hold a load-use stall for 65540 cycles from a cleared state.
    quiet();
    rst = 1;
    cycle();
    rst = 0;
    fetch_bus.if_instruction = mk(0, 3, 0, 0);
    cycle();
    exe_mem_read = 1; exe_dest = 3;
    for (int i = 0; i < 65540; i++) cycle();
    check_eq("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
    rst = 1;
    #1;
    check_eq("rst_in_stall_freeze", 32'(fetch_bus.freeze), 32'd0);
    cycle();
    rst = 0;
    quiet();
    #1;
    check_eq("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check_eq("post_rst_id_instruction", id_instruction, 32'd0);
    check_eq("post_rst_id_pc", id_pc, 32'd0);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
